adau_i2s_tx: RTL and testbench
==============================

# adau_i2s_tx

Audio playback transmitter between the CPU bus logic and the ADAU codec serial port. Accepts stereo 24-bit sample pairs through the same push/full handshake the bus logic drives (`adau_audio_l`, `adau_audio_r`, `adau_audio_valid`, `adau_audio_full`). Buffers them in an internal FIFO and serialises them as an I2S master (BCLK, LRCLK, SDATA) derived from the system clock. One FIFO entry is consumed per I2S frame.

## Interface
- `FIFO_DEPTH`, 16: sample-pair entries; power of two, ≥2.
- `BCLK_DIV`, 8: `clk` cycles per BCLK half-period; ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `audio_l`  in  24  left sample, two's complement.
- `audio_r`  in  24  right sample, two's complement.
- `audio_valid`  in  1  push request for {`audio_l`, `audio_r`}.
- `audio_full`  out  1  FIFO full, registered.
- `enable`  in  1  transmit enable; connected to `adau_init_done`.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data, MSB first.
- `underrun`  out  1  one-`clk` pulse when a frame starts with the FIFO empty.

## Operation
- **Push:** an entry is written on every `clk` edge where `audio_valid && !audio_full`. There is one push per cycle. A push attempted while full is dropped, and pointers do not change.
- **FIFO:** write and read pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Count = wptr − rptr.
  - `audio_full` is registered: high from the cycle after count reaches FIFO_DEPTH.
  - On a simultaneous push and pop, count is unchanged. At full, the push is still blocked because `audio_full` is high.
- **Bit-clock divider:** a counter runs 0..BCLK_DIV−1 and `bclk` toggles on wrap. It runs only in state RUN.
- **States:**
  - IDLE: `bclk`=0, `lrclk`=1, `sdata`=0. Moves to RUN when `enable`=1.
  - RUN: 32 BCLK slots per channel, 64 per frame.
  - RUN → IDLE only at a frame boundary with `enable`=0. The current frame always completes, then the block parks at IDLE values.
- **Frame start:** the `bclk` falling edge where `lrclk` goes 1→0.
  - In that same `clk` cycle, one entry is popped into the {L,R} shift registers.
  - If the FIFO is empty, nothing is popped, `underrun` pulses for one cycle, and zeros are loaded.
- **Slot mapping per channel:** slot 0 = 0 (I2S one-bit delay), slots 1–24 = bits 23..0, slots 25–31 = 0.
- **Output timing:** `lrclk` and `sdata` change only on `bclk` falling edges. The codec samples them on rising edges.
- **Reset mid-frame:** the FIFO is emptied and the block returns to IDLE immediately. Partial frames are lost.

## Timing
- Reset values: `audio_full`=0, `bclk`=0, `lrclk`=1, `sdata`=0, `underrun`=0. Pointers and divider are 0 and the state is IDLE.
- Full flag: `audio_full` rises on the first edge after the push that fills the FIFO. It falls on the first edge after a pop from full.
- Enable start-up: the first `bclk` falling edge occurs 2·BCLK_DIV `clk` cycles after `enable` is sampled high in IDLE. That edge is the first frame start.
- Frame period: 128·BCLK_DIV `clk` cycles.
- Latency: a pair pushed while the FIFO is empty is transmitted in the next frame starting at least one `clk` after the push. If the push and the frame-start pop coincide on the same edge, the pair misses that frame.
- Bit timing: MSB bit 23 of left appears on `sdata` at the second `bclk` falling edge of the frame. That is BCLK_DIV·2 `clk` cycles after `lrclk` falls.

## Configuration
- `ADAU_TX_HOLD_LAST_EN` defined: on underrun, the previously transmitted {L,R} pair is repeated, or zeros if none has been sent since reset. `underrun` still pulses.
- `ADAU_TX_HOLD_LAST_EN` undefined: zeros are transmitted on underrun.

## Test plan
- **Reset:** assert `reset` asynchronously mid-frame → all outputs take their reset values without a `clk` edge, and `audio_full`=0.
- **Single pair:** push L=0x800001, R=0x7FFFFE, then raise `enable` (BCLK_DIV=2).
  - Left slots 1–24 carry 1000…0001 and the other left slots are 0.
  - Right slots 1–24 carry 0111…1110.
  - `lrclk` is low for exactly 32 BCLKs.
- **Fill and block:** with `enable`=0, push 17 pairs on consecutive cycles → `audio_full`=1 after the 16th, and the 17th is dropped. Then enable → exactly the 16 pushed pairs are sent in order, followed by underrun frames.
- **Underrun:** enable with the FIFO empty → `underrun` pulses once per frame start and `sdata` stays 0. With `ADAU_TX_HOLD_LAST_EN` defined, after a pair 0x123456/0x654321 drains, the same pair repeats every frame.
- **Push/pop collision:** at full, hold `audio_valid`=1 → exactly one push is accepted on the cycle after the frame-start pop, and `audio_full` returns to 1.
- **Enable drop mid-frame:** deassert `enable` at slot 40 → the frame completes all 64 slots, then the outputs park at `bclk`=0, `lrclk`=1, and no further pops occur.

Source files
------------

// File: rtl/adau_i2s_tx.sv
// +----------------------------------------------------------------------------+
// | adau_i2s_tx : stereo 24-bit I2S master transmitter with push/full FIFO.    |
// | Option macro: ADAU_TX_HOLD_LAST_EN (repeat last pair on underrun).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module adau_i2s_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int BCLK_DIV   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] audio_l,
  input  logic [23:0] audio_r,
  input  logic        audio_valid,
  output logic        audio_full,
  input  logic        enable,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_div_w  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [c_div_w-1:0]  c_div_max = c_div_w'(BCLK_DIV - 1);
  localparam logic [c_addr_w:0]   c_depth   = (c_addr_w + 1)'(FIFO_DEPTH);
  localparam logic [5:0]          c_slot_last = 6'd63;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [47:0]       r_mem [FIFO_DEPTH];
  logic [c_addr_w:0] r_wptr;
  logic [c_addr_w:0] r_rptr;
  logic              r_full;
  logic [c_addr_w:0] w_count;
  logic [c_addr_w:0] w_count_n;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  state_t            r_state;
  state_t            w_state_n;
  logic [c_div_w-1:0] r_div;
  logic [c_div_w-1:0] w_div_n;
  logic              r_bclk;
  logic              w_bclk_n;
  logic [5:0]        r_slot;
  logic [5:0]        w_slot_n;
  logic [5:0]        w_slot_inc;
  logic              r_lrclk;
  logic              w_lrclk_n;
  logic              r_sdata;
  logic              w_sdata_n;
  logic [63:0]       r_sh;
  logic [63:0]       w_sh_n;
  logic              r_underrun;
  logic              w_underrun_n;

  logic [47:0]       w_fill;
  logic [47:0]       w_src;
  logic [63:0]       w_word;

  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == '0);
  assign w_push     = audio_valid && !r_full;
  assign w_count_n  = w_count + {{c_addr_w{1'b0}}, w_push} - {{c_addr_w{1'b0}}, w_pop};
  assign w_slot_inc = r_slot + 6'd1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_addr_w-1:0]] <= {audio_l, audio_r};
    end
  end

  // Full is derived from the post-edge count so a push never lands on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_full <= (w_count_n == c_depth);
    end
  end

`ifdef ADAU_TX_HOLD_LAST_EN
  logic [47:0] r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_src;
    end
  end

  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  assign w_src  = w_empty ? w_fill : r_mem[r_rptr[c_addr_w-1:0]];
  // Per channel: one-bit delay slot, 24 data bits MSB first, 7 pad slots.
  assign w_word = {1'b0, w_src[47:24], 7'b0, 1'b0, w_src[23:0], 7'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_slot     <= c_slot_last;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_sh       <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_div      <= w_div_n;
      r_bclk     <= w_bclk_n;
      r_slot     <= w_slot_n;
      r_lrclk    <= w_lrclk_n;
      r_sdata    <= w_sdata_n;
      r_sh       <= w_sh_n;
      r_underrun <= w_underrun_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_div_n      = r_div;
    w_bclk_n     = r_bclk;
    w_slot_n     = r_slot;
    w_lrclk_n    = r_lrclk;
    w_sdata_n    = r_sdata;
    w_sh_n       = r_sh;
    w_pop        = 1'b0;
    w_underrun_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Parking at the last slot makes the first falling edge a frame start.
        w_div_n   = '0;
        w_bclk_n  = 1'b0;
        w_slot_n  = c_slot_last;
        w_lrclk_n = 1'b1;
        w_sdata_n = 1'b0;
        if (enable) w_state_n = ST_RUN;
      end
      ST_RUN: begin
        if (r_div != c_div_max) begin
          w_div_n = r_div + c_div_w'(1);
        end else begin
          w_div_n  = '0;
          w_bclk_n = !r_bclk;
          if (r_bclk) begin
            if ((r_slot == c_slot_last) && !enable) begin
              w_state_n = ST_IDLE;
              w_lrclk_n = 1'b1;
              w_sdata_n = 1'b0;
            end else if (r_slot == c_slot_last) begin
              w_slot_n     = 6'd0;
              w_pop        = !w_empty;
              w_underrun_n = w_empty;
              w_lrclk_n    = 1'b0;
              w_sdata_n    = w_word[63];
              w_sh_n       = {w_word[62:0], 1'b0};
            end else begin
              w_slot_n  = w_slot_inc;
              w_lrclk_n = w_slot_inc[5];
              w_sdata_n = r_sh[63];
              w_sh_n    = {r_sh[62:0], 1'b0};
            end
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign audio_full = r_full;
  assign bclk       = r_bclk;
  assign lrclk      = r_lrclk;
  assign sdata      = r_sdata;
  assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_adau_i2s_tx.sv
// +----------------------------------------------------------------------------+
// | tb_adau_i2s_tx : scoreboard bench for adau_i2s_tx (frame-level model).     |
// | Revision       : 1.0 - initial release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_adau_i2s_tx;

  localparam int DEPTH = 16;
  localparam int B     = 2;
  localparam int FRAME = 128 * B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] audio_l = '0;
  logic [23:0] audio_r = '0;
  logic        audio_valid = 1'b0;
  logic        enable = 1'b0;
  logic        audio_full;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  adau_i2s_tx #(.FIFO_DEPTH(DEPTH), .BCLK_DIV(B)) dut (
    .clk(clk), .reset(reset), .audio_l(audio_l), .audio_r(audio_r),
    .audio_valid(audio_valid), .audio_full(audio_full), .enable(enable),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame starts scheduled by cycle arithmetic.
  logic [47:0] mq[$];
  logic [47:0] ef[$];
  bit          m_run = 0;
  int          m_cnt = 0;
  bit          m_und = 0;
  logic [47:0] m_last = '0;

  always @(posedge clk or posedge reset) begin
    bit          acc;
    logic [47:0] pr;
    if (reset) begin
      mq.delete();
      ef.delete();
      m_run  = 0;
      m_cnt  = 0;
      m_und  = 0;
      m_last = '0;
    end else begin
      acc   = audio_valid && (mq.size() < DEPTH);
      m_und = 0;
      if (m_run) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (!enable) begin
            m_run = 0;
          end else begin
            if (mq.size() > 0) begin
              pr     = mq.pop_front();
              m_last = pr;
            end else begin
              m_und = 1;
`ifdef ADAU_TX_HOLD_LAST_EN
              pr = m_last;
`else
              pr = '0;
`endif
            end
            ef.push_back(pr);
            m_cnt = FRAME;
          end
        end
      end else if (enable) begin
        m_run = 1;
        m_cnt = 2 * B;
      end
      if (acc) mq.push_back({audio_l, audio_r});
    end
  end

  // Monitor: codec-style capture on bclk rising edges, frame-level compare.
  bit          coll = 0;
  int          nb = 0;
  logic        prev_b = 1'b0;
  logic        prev_lr = 1'b1;
  logic [63:0] bits;
  logic [63:0] lrs;

  always @(negedge clk) begin
    logic [47:0] pr;
    logic [23:0] gl;
    logic [23:0] gr;
    logic        pad;
    if (reset) begin
      coll    = 0;
      nb      = 0;
      prev_b  = 1'b0;
      prev_lr = 1'b1;
    end else begin
      chk("full", {63'b0, audio_full}, {63'b0, mq.size() == DEPTH});
      chk("underrun", {63'b0, underrun}, {63'b0, m_und});
      if (!m_run) chk("idle_outputs", {61'b0, bclk, lrclk, sdata}, 64'b010);
      if (bclk && !prev_b) begin
        if (!coll && !lrclk && prev_lr) begin
          coll = 1;
          nb   = 0;
        end
        if (coll) begin
          bits[nb] = sdata;
          lrs[nb]  = lrclk;
          nb++;
          if (nb == 64) begin
            coll = 0;
            if (ef.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL frame_unexpected: got a frame expected none at %0t", $time);
            end else begin
              pr = ef.pop_front();
              for (int i = 0; i < 24; i++) begin
                gl[23-i] = bits[1+i];
                gr[23-i] = bits[33+i];
              end
              pad = bits[0] | bits[32] | (|bits[31:25]) | (|bits[63:57]);
              chk("frame_left", {40'b0, gl}, {40'b0, pr[47:24]});
              chk("frame_right", {40'b0, gr}, {40'b0, pr[23:0]});
              chk("frame_pad", {63'b0, pad}, 64'b0);
              chk("lrclk_pattern", lrs, {32'hFFFF_FFFF, 32'h0});
            end
          end
        end
        prev_lr = lrclk;
      end
      prev_b = bclk;
    end
  end

  task automatic drive(input bit v);
    @(negedge clk);
    audio_valid = v;
    audio_l     = 24'($urandom);
    audio_r     = 24'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"}, {63'b0, audio_full}, 64'b0);
    chk({tag, "_bclk"}, {63'b0, bclk}, 64'b0);
    chk({tag, "_lrclk"}, {63'b0, lrclk}, 64'b1);
    chk({tag, "_sdata"}, {63'b0, sdata}, 64'b0);
    chk({tag, "_underrun"}, {63'b0, underrun}, 64'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Single pair, then enable dropped mid-frame in the following frame.
    @(negedge clk);
    audio_valid = 1'b1;
    audio_l     = 24'h800001;
    audio_r     = 24'h7FFFFE;
    @(negedge clk);
    audio_valid = 1'b0;
    enable      = 1'b1;
    repeat (4 + FRAME + 160 - 1) @(negedge clk);
    enable = 1'b0;
    repeat (FRAME + 40) @(negedge clk);

    // Fill with 17 pushes while disabled, then run with valid held high.
    for (int i = 0; i < 17; i++) drive(1'b1);
    drive(1'b1);
    enable = 1'b1;
    repeat (3 * FRAME + 37) drive(1'b1);

    // Asynchronous reset between clock edges, mid-frame, with FIFO full.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    audio_valid = 1'b0;
    enable      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with enable toggling.
    @(negedge clk);
    audio_valid = 1'b1;
    audio_l     = 24'h123456;
    audio_r     = 24'h654321;
    enable      = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(200, 800);
      repeat (n) drive($urandom_range(0, 99) < 2);
      enable = 1'b0;
      n = $urandom_range(20, 300);
      repeat (n) drive($urandom_range(0, 99) < 2);
      enable = 1'b1;
    end

    // Drain, park, and confirm every scheduled frame was observed.
    drive(1'b0);
    repeat ((DEPTH + 2) * FRAME) @(negedge clk);
    enable = 1'b0;
    repeat (2 * FRAME + 20) @(negedge clk);
    chk("frames_pending", 64'(ef.size()), 64'd0);
    chk("park_bclk_lrclk", {62'b0, bclk, lrclk}, 64'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
